// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one-cycle memory reads, holds the fetched word for execute,
// and redirects the PC on acknowledge. Define IF_MISALIGN_TRAP_EN to trap on misaligned targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] pc,
  input  logic        instr_ack,
  input  logic [1:0]  BranchNoCondition,
  input  logic        branch_taken,
  input  logic [31:0] imm32,
  input  logic [31:0] jalr_target,
  output logic [31:0] instret,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, TRAP} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] next_pc_raw;

  // Redirect target; branch_taken only matters for the plain sequential/branch encoding.
  always_comb begin
    next_pc_raw = pc_q + 32'd4;
    case (BranchNoCondition)
      2'b00:   next_pc_raw = branch_taken ? (pc_q + imm32) : (pc_q + 32'd4);
      2'b01:   next_pc_raw = pc_q + imm32;
      2'b10:   next_pc_raw = {jalr_target[XLEN-1:1], 1'b0};
      default: next_pc_raw = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    instret_d  = instret_q;
    misalign_d = misalign_q;
    case (state_q)
      // Out of reset the request is not yet up, so FETCH first raises it, then moves on.
      FETCH: begin
        if (req_q) begin
          state_d = WAIT;
        end else begin
          req_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          valid_d   = 1'b0;
          instret_d = instret_q + 32'd1;
`ifdef IF_MISALIGN_TRAP_EN
          pc_d = next_pc_raw;
          if (next_pc_raw[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            req_d   = 1'b1;
            state_d = FETCH;
          end
`else
          pc_d    = {next_pc_raw[XLEN-1:2], 2'b00};
          req_d   = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      instret_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      instret_q  <= instret_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign func3       = instr_q[14:12];
  assign func7       = instr_q[31:25];
  assign pc          = pc_q;
  assign instret     = instret_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of fetch/redirect transactions plus hand sequences
// for reset abort, misaligned jalr target (IF_MISALIGN_TRAP_EN aware) and retire-counter wrap.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned NVEC = 8;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc;
  logic        instr_ack;
  logic [1:0]  bnc;
  logic        branch_taken;
  logic [31:0] imm32;
  logic [31:0] jalr_target;
  logic [31:0] instret;
  logic        misalign_err;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .func3(func3), .func7(func7), .pc(pc),
    .instr_ack(instr_ack), .BranchNoCondition(bnc), .branch_taken(branch_taken),
    .imm32(imm32), .jalr_target(jalr_target),
    .instret(instret), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] word;
    int          lat;
    logic        spur;
    logic        early;
    int          hold;
    logic [1:0]  bnc;
    logic        taken;
    logic [31:0] imm;
    logic [31:0] jalr;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [31:0] e_next;
  } vec_t;

  vec_t        vecs [NVEC];
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    instr_ack    = 1'b0;
    bnc          = 2'b00;
    branch_taken = 1'b0;
    imm32        = '0;
    jalr_target  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc      = RESET_PC;
    exp_instret = '0;
  endtask

  // Wait (bounded) for the read request and check its address.
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("imem_addr", imem_addr, exp_pc);
  endtask

  // Act as memory: optional junk rvalid in the request cycle, then data after lat idle cycles.
  task automatic serve(input logic [31:0] word, input int lat, input logic spur, input logic early);
    wait_req();
    if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
    end
    if (early) begin
      instr_ack = 1'b1;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("req_dropped", 32'(imem_req), 32'd0);
    chk("valid_in_wait", 32'(instr_valid), 32'd0);
    repeat (lat) @(negedge clk);
    instr_ack   = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, word);
  endtask

  task automatic ack_with(input logic [1:0] m, input logic t, input logic [31:0] imm,
                          input logic [31:0] jt);
    bnc          = m;
    branch_taken = t;
    imm32        = imm;
    jalr_target  = jt;
    instr_ack    = 1'b1;
    @(negedge clk);
    clear_inputs();
    exp_instret = exp_instret + 32'd1;
    chk("valid_after_ack", 32'(instr_valid), 32'd0);
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // word, lat, spur, early, hold, bnc, taken, imm, jalr, opcode, func3, func7, next_pc
    vecs[0] = '{32'h0050_0093, 0, 1'b0, 1'b0, 0,  2'b01, 1'b0, 32'h0000_0100, 32'h0,
                7'h13, 3'd0, 7'h00, 32'h0000_0100};
    vecs[1] = '{32'h0020_8463, 1, 1'b1, 1'b0, 0,  2'b00, 1'b1, 32'hFFFF_FFF0, 32'h0,
                7'h63, 3'd0, 7'h00, 32'h0000_00F0};
    vecs[2] = '{32'h4020_8033, 5, 1'b1, 1'b1, 10, 2'b00, 1'b0, 32'h0000_0040, 32'h0,
                7'h33, 3'd0, 7'h20, 32'h0000_00F4};
    vecs[3] = '{32'h0020_C0B3, 2, 1'b0, 1'b0, 0,  2'b11, 1'b1, 32'h0000_1000, 32'h0,
                7'h33, 3'd4, 7'h00, 32'h0000_00F8};
    vecs[4] = '{32'hFE00_0FE3, 0, 1'b0, 1'b1, 0,  2'b01, 1'b0, 32'hFFFF_FF08, 32'h0,
                7'h63, 3'd0, 7'h7F, 32'h0000_0000};
    vecs[5] = '{32'h0000_0067, 3, 1'b0, 1'b0, 0,  2'b10, 1'b1, 32'h0000_0999, 32'h0000_0041,
                7'h67, 3'd0, 7'h00, 32'h0000_0040};
    vecs[6] = '{32'h1234_5678, 0, 1'b1, 1'b0, 2,  2'b00, 1'b1, 32'hFFFF_FFBC, 32'h0,
                7'h78, 3'd5, 7'h09, 32'hFFFF_FFFC};
    vecs[7] = '{32'hFFFF_FFFF, 1, 1'b0, 1'b0, 0,  2'b00, 1'b0, 32'h0000_0000, 32'h0,
                7'h7F, 3'd7, 7'h7F, 32'h0000_0000};

    rst = 1'b1;
    clear_inputs();
    exp_pc      = RESET_PC;
    exp_instret = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_opcode", 32'(opcode), 32'h13);
    chk("rst_func3", 32'(func3), 32'd0);
    chk("rst_func7", 32'(func7), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      serve(vecs[i].word, vecs[i].lat, vecs[i].spur, vecs[i].early);
      chk("opcode", 32'(opcode), 32'(vecs[i].e_op));
      chk("func3", 32'(func3), 32'(vecs[i].e_f3));
      chk("func7", 32'(func7), 32'(vecs[i].e_f7));
      chk("pc", pc, exp_pc);
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(negedge clk);
        chk("hold_instr", instr, vecs[i].word);
      end
      chk("hold_pc", pc, exp_pc);
      ack_with(vecs[i].bnc, vecs[i].taken, vecs[i].imm, vecs[i].jalr);
      exp_pc = vecs[i].e_next;
    end

    // jal to 0x40, then jalr with target 0x203 (bit 0 cleared -> 0x202, still misaligned).
    serve(32'h0400_006F, 0, 1'b0, 1'b0);
    ack_with(2'b01, 1'b0, 32'h0000_0040, 32'h0);
    exp_pc = 32'h0000_0040;
    serve(32'h0000_8067, 1, 1'b0, 1'b0);
    chk("jalr_pc", pc, exp_pc);
    ack_with(2'b10, 1'b1, 32'h0000_0007, 32'h0000_0203);
`ifdef IF_MISALIGN_TRAP_EN
    chk("trap_pc", pc, 32'h0000_0202);
    for (int c = 0; c < 5; c++) begin
      chk("trap_misalign", 32'(misalign_err), 32'd1);
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    do_reset();
`else
    chk("no_trap_misalign", 32'(misalign_err), 32'd0);
    exp_pc = 32'h0000_0200;
`endif

    // Reset asserted in WAIT while memory returns data on the same edge.
    wait_req();
    @(negedge clk);
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("abort_instr", instr, 32'h0000_0013);
    chk("abort_pc", pc, RESET_PC);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_instret", instret, 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    exp_pc      = RESET_PC;
    exp_instret = '0;

    // First edge after release raises the request; data lands on the third edge.
    chk("pre_edge_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("edge1_req", 32'(imem_req), 32'd1);
    serve(32'h0050_0093, 0, 1'b0, 1'b0);
    chk("refetch_opcode", 32'(opcode), 32'h13);
    chk("refetch_func3", 32'(func3), 32'd0);

    // Retire counter wrap: preload near the top, then two acknowledges.
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    ack_with(2'b00, 1'b0, 32'h0, 32'h0);
    exp_pc = RESET_PC + 32'd4;
    serve(32'h0000_0013, 0, 1'b0, 1'b0);
    ack_with(2'b00, 1'b0, 32'h0, 32'h0);
    chk("instret_wrapped", instret, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
